// File: rtl/scalar_mul_ctrl_if.sv
// Bus bundle for scalar_mul_ctrl: start/result handshake plus point-add unit port.
// master = controller side, slave = environment (requester and point-add unit).
interface scalar_mul_ctrl_if #(
    parameter int DATA_WIDTH = 256
);
    logic [DATA_WIDTH-1:0] k;
    logic [DATA_WIDTH-1:0] Gx;
    logic [DATA_WIDTH-1:0] Gy;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] Rx;
    logic [DATA_WIDTH-1:0] Ry;
    logic                  out_valid;
    logic                  busy;
    logic [DATA_WIDTH-1:0] add_Px;
    logic [DATA_WIDTH-1:0] add_Py;
    logic [DATA_WIDTH-1:0] add_Qx;
    logic [DATA_WIDTH-1:0] add_Qy;
    logic                  add_in_valid;
    logic [DATA_WIDTH-1:0] add_Rx;
    logic [DATA_WIDTH-1:0] add_Ry;
    logic                  add_out_valid;

    modport master (
        input  k, Gx, Gy, in_valid,
        input  add_Rx, add_Ry, add_out_valid,
        output Rx, Ry, out_valid, busy,
        output add_Px, add_Py, add_Qx, add_Qy, add_in_valid
    );

    modport slave (
        output k, Gx, Gy, in_valid,
        output add_Rx, add_Ry, add_out_valid,
        input  Rx, Ry, out_valid, busy,
        input  add_Px, add_Py, add_Qx, add_Qy, add_in_valid
    );
endinterface

// File: rtl/scalar_mul_ctrl.sv
// LSB-first double-and-add scalar multiplier controller driving an external point-add unit.
// Optional macro SCALAR_MUL_EARLY_EXIT_EN: finish once no set scalar bits remain.
module scalar_mul_ctrl #(
    parameter int DATA_WIDTH = 256
) (
    input logic               clk,
    input logic               rst,
    scalar_mul_ctrl_if.master bus
);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] EVAL     = 3'd1;
    localparam logic [2:0] ADD_REQ  = 3'd2;
    localparam logic [2:0] ADD_WAIT = 3'd3;
    localparam logic [2:0] DBL_REQ  = 3'd4;
    localparam logic [2:0] DBL_WAIT = 3'd5;
    localparam logic [2:0] DONE     = 3'd6;

    logic [2:0]            state;
    logic [DATA_WIDTH-1:0] k_sh;
    logic [DATA_WIDTH-1:0] tx, ty;
    logic [DATA_WIDTH-1:0] ax, ay;
    logic [DATA_WIDTH-1:0] rx, ry;
    logic [IW-1:0]         idx;
    logic                  out_valid_q;
    logic                  last;
    logic                  is_add, is_dbl;
    logic [DATA_WIDTH-1:0] px, py, qx, qy;

`ifdef SCALAR_MUL_EARLY_EXIT_EN
    // k_sh == 0 also satisfies this, so EVAL exits straight to DONE.
    assign last = (idx == IW'(DATA_WIDTH - 1)) || ((k_sh >> 1) == '0);
`else
    assign last = (idx == IW'(DATA_WIDTH - 1));
`endif

    assign is_add = (state == ADD_REQ) || (state == ADD_WAIT);
    assign is_dbl = (state == DBL_REQ) || (state == DBL_WAIT);

    // Operands are a pure function of state; T and acc only change on leaving WAIT.
    always_comb begin
        px = '0;
        py = '0;
        qx = '0;
        qy = '0;
        unique case (1'b1)
            is_add: begin
                px = tx;
                py = ty;
                qx = ax;
                qy = ay;
            end
            is_dbl: begin
                px = tx;
                py = ty;
                qx = tx;
                qy = ty;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            k_sh        <= '0;
            tx          <= '0;
            ty          <= '0;
            ax          <= '0;
            ay          <= '0;
            rx          <= '0;
            ry          <= '0;
            idx         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        k_sh  <= bus.k;
                        tx    <= bus.Gx;
                        ty    <= bus.Gy;
                        ax    <= '0;
                        ay    <= '0;
                        idx   <= '0;
                        state <= EVAL;
                    end
                end
                EVAL: begin
                    if (k_sh[0])   state <= ADD_REQ;
                    else if (last) state <= DONE;
                    else           state <= DBL_REQ;
                end
                ADD_REQ: state <= ADD_WAIT;
                ADD_WAIT: begin
                    if (bus.add_out_valid) begin
                        ax    <= bus.add_Rx;
                        ay    <= bus.add_Ry;
                        state <= last ? DONE : DBL_REQ;
                    end
                end
                DBL_REQ: state <= DBL_WAIT;
                DBL_WAIT: begin
                    if (bus.add_out_valid) begin
                        tx    <= bus.add_Rx;
                        ty    <= bus.add_Ry;
                        k_sh  <= k_sh >> 1;
                        idx   <= idx + IW'(1);
                        state <= EVAL;
                    end
                end
                DONE: begin
                    rx          <= ax;
                    ry          <= ay;
                    out_valid_q <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Rx           = rx;
    assign bus.Ry           = ry;
    assign bus.out_valid    = out_valid_q;
    assign bus.busy         = (state != IDLE);
    assign bus.add_Px       = px;
    assign bus.add_Py       = py;
    assign bus.add_Qx       = qx;
    assign bus.add_Qy       = qy;
    assign bus.add_in_valid = (state == ADD_REQ) || (state == DBL_REQ);
endmodule
